// File: rtl/tcdm_amo_bank.sv
// TCDM bank responder: single-cycle read/write with read-first data return,
// plus in-bank atomics executed as a two-cycle read-modify-write.
module tcdm_amo_bank #(
  parameter int unsigned AddrWidth    = 10,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned BeWidth      = DataWidth / 8,
  parameter int unsigned AmoWidth     = 4,
  parameter int unsigned ReqDataWidth = AmoWidth + 1 + BeWidth + AddrWidth + DataWidth
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ReqDataWidth-1:0] data_i,
  output logic [DataWidth-1:0]    rdata_o
);

  localparam int unsigned NumWords = 2 ** AddrWidth;
  localparam int unsigned WenBit   = BeWidth + AddrWidth + DataWidth;

  localparam logic [AmoWidth-1:0] AMO_SWAP = AmoWidth'(1);
  localparam logic [AmoWidth-1:0] AMO_ADD  = AmoWidth'(2);
  localparam logic [AmoWidth-1:0] AMO_AND  = AmoWidth'(3);
  localparam logic [AmoWidth-1:0] AMO_OR   = AmoWidth'(4);
  localparam logic [AmoWidth-1:0] AMO_XOR  = AmoWidth'(5);
  localparam logic [AmoWidth-1:0] AMO_MAX  = AmoWidth'(6);
  localparam logic [AmoWidth-1:0] AMO_MAXU = AmoWidth'(7);
  localparam logic [AmoWidth-1:0] AMO_MIN  = AmoWidth'(8);
  localparam logic [AmoWidth-1:0] AMO_MINU = AmoWidth'(9);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    AMO_WB = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [DataWidth-1:0] mem_q [NumWords];

  logic [AddrWidth-1:0] amo_addr_q, amo_addr_d;
  logic [DataWidth-1:0] amo_wdata_q, amo_wdata_d;
  logic [AmoWidth-1:0]  amo_op_q, amo_op_d;
  logic [DataWidth-1:0] amo_old_q, amo_old_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;

  // Request payload fields
  logic [AmoWidth-1:0]  req_amo;
  logic                 req_wen;
  logic [BeWidth-1:0]   req_be;
  logic [AddrWidth-1:0] req_addr;
  logic [DataWidth-1:0] req_wdata;
  logic                 req_is_amo;

  assign req_amo    = data_i[ReqDataWidth-1 -: AmoWidth];
  assign req_wen    = data_i[WenBit];
  assign req_be     = data_i[WenBit-1 -: BeWidth];
  assign req_addr   = data_i[DataWidth +: AddrWidth];
  assign req_wdata  = data_i[DataWidth-1:0];
  assign req_is_amo = (req_amo >= AMO_SWAP) && (req_amo <= AMO_MINU);

  logic [DataWidth-1:0] old_word;
  logic [DataWidth-1:0] merged_word;
  logic [DataWidth-1:0] amo_new;
  logic                 mem_we;
  logic [AddrWidth-1:0] mem_waddr;
  logic [DataWidth-1:0] mem_wdata;

  assign old_word = mem_q[req_addr];

  // Byte-enable merge of write data over the current word
  always_comb begin
    merged_word = old_word;
    for (int unsigned i = 0; i < BeWidth; i++) begin
      if (req_be[i]) begin
        merged_word[8*i +: 8] = req_wdata[8*i +: 8];
      end
    end
  end

  // AMO result from the latched old word and operand
  always_comb begin
    amo_new = amo_wdata_q;
    case (amo_op_q)
      AMO_SWAP: amo_new = amo_wdata_q;
      AMO_ADD:  amo_new = amo_old_q + amo_wdata_q;
      AMO_AND:  amo_new = amo_old_q & amo_wdata_q;
      AMO_OR:   amo_new = amo_old_q | amo_wdata_q;
      AMO_XOR:  amo_new = amo_old_q ^ amo_wdata_q;
      AMO_MAX:  amo_new = ($signed(amo_old_q) > $signed(amo_wdata_q)) ? amo_old_q : amo_wdata_q;
      AMO_MAXU: amo_new = (amo_old_q > amo_wdata_q) ? amo_old_q : amo_wdata_q;
      AMO_MIN:  amo_new = ($signed(amo_old_q) < $signed(amo_wdata_q)) ? amo_old_q : amo_wdata_q;
      AMO_MINU: amo_new = (amo_old_q < amo_wdata_q) ? amo_old_q : amo_wdata_q;
      default:  amo_new = amo_wdata_q;
    endcase
  end

  // Next-state, grant and memory write control
  always_comb begin
    state_d     = state_q;
    amo_addr_d  = amo_addr_q;
    amo_wdata_d = amo_wdata_q;
    amo_op_d    = amo_op_q;
    amo_old_d   = amo_old_q;
    mem_we      = 1'b0;
    mem_waddr   = req_addr;
    mem_wdata   = merged_word;
    gnt_o       = 1'b0;

    case (state_q)
      IDLE: begin
        // Grant is held low during reset so nothing is accepted
        gnt_o = req_i & rst_ni;
        if (gnt_o) begin
          if (req_is_amo) begin
            amo_addr_d  = req_addr;
            amo_wdata_d = req_wdata;
            amo_op_d    = req_amo;
            amo_old_d   = old_word;
            state_d     = AMO_WB;
          end else if (req_wen) begin
            mem_we = 1'b1;
          end
        end
      end
      AMO_WB: begin
        mem_we    = 1'b1;
        mem_waddr = amo_addr_q;
        mem_wdata = amo_new;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data returns the pre-update word in the cycle after grant
  always_comb begin
    rdata_d = rdata_q;
    if (gnt_o) begin
      rdata_d = old_word;
    end
  end

  // Control and response registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      amo_addr_q  <= '0;
      amo_wdata_q <= '0;
      amo_op_q    <= '0;
      amo_old_q   <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      amo_addr_q  <= amo_addr_d;
      amo_wdata_q <= amo_wdata_d;
      amo_op_q    <= amo_op_d;
      amo_old_q   <= amo_old_d;
      rdata_q     <= rdata_d;
    end
  end

  // Storage array, not reset; reset forces IDLE so a pending write-back is dropped
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_tcdm_amo_bank.sv
// Bench for tcdm_amo_bank: directed scenarios plus randomized traffic
// checked against a word-array reference model.
module tb_tcdm_amo_bank;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned MW = 4;
  localparam int unsigned RW = MW + 1 + BW + AW + DW;

  logic          clk_i;
  logic          rst_ni;
  logic          req_i;
  logic          gnt_o;
  logic [RW-1:0] data_i;
  logic [DW-1:0] rdata_o;

  tcdm_amo_bank dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req_i),
    .gnt_o   (gnt_o),
    .data_i  (data_i),
    .rdata_o (rdata_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: word array, one pending AMO result, expected response
  logic [31:0] m_mem [1024];
  bit          m_busy;
  logic [9:0]  m_paddr;
  logic [31:0] m_pval;
  logic [31:0] m_rdata;
  bit          exp_gnt;
  logic        obs_gnt;

  function automatic logic [31:0] amo_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      4'd1: return b;
      4'd2: return a + b;
      4'd3: return a & b;
      4'd4: return a | b;
      4'd5: return a ^ b;
      4'd6: return (int'(a) > int'(b)) ? a : b;
      4'd7: return (a > b) ? a : b;
      4'd8: return (int'(a) < int'(b)) ? a : b;
      4'd9: return (a < b) ? a : b;
      default: return a;
    endcase
  endfunction

  // One clock of stimulus; records observed grant and advances the model
  task automatic step(input bit req, input logic [3:0] amo, input bit wen,
                      input logic [3:0] be, input logic [9:0] addr, input logic [31:0] wd);
    @(negedge clk_i);
    req_i  = req;
    data_i = {amo, wen, be, addr, wd};
    #1 obs_gnt = gnt_o;
    exp_gnt = req && !m_busy;
    if (m_busy) begin
      m_mem[m_paddr] = m_pval;
      m_busy = 1'b0;
    end else if (exp_gnt) begin
      m_rdata = m_mem[addr];
      if (amo >= 4'd1 && amo <= 4'd9) begin
        m_busy  = 1'b1;
        m_paddr = addr;
        m_pval  = amo_fn(amo, m_mem[addr], wd);
      end else if (wen) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) m_mem[addr][8*i +: 8] = wd[8*i +: 8];
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    req_i  = 1'b1;
    data_i = '0;
    m_busy = 1'b0;
    m_rdata = 32'h0;
    #3;
    checks++;
    if (gnt_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_gnt got %b want 0", gnt_o);
    end
    checks++;
    if (rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h want 0", rdata_o);
    end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    req_i  = 1'b0;
  endtask

  task automatic test_fill();
    for (int a = 0; a < 1024; a++) step(1'b1, 4'd0, 1'b1, 4'hF, 10'(a), $urandom);
    step(1'b0, 4'd0, 1'b0, 4'h0, 10'd0, 32'h0);
  endtask

  task automatic test_write_read();
    step(1'b1, 4'd0, 1'b1, 4'hF, 10'd5, 32'hDEADBEEF);
    step(1'b1, 4'd0, 1'b0, 4'hF, 10'd5, 32'h0);
    checks++;
    if (obs_gnt !== 1'b1) begin
      errors++;
      $display("FAIL wr_rd_gnt got %b want 1", obs_gnt);
    end
    checks++;
    if (rdata_o !== 32'hDEADBEEF || rdata_o !== m_rdata) begin
      errors++;
      $display("FAIL wr_rd_data got %h want %h", rdata_o, 32'hDEADBEEF);
    end
  endtask

  task automatic test_partial();
    step(1'b1, 4'd0, 1'b1, 4'hF, 10'd3, 32'h11223344);
    step(1'b1, 4'd0, 1'b1, 4'h5, 10'd3, 32'hAABBCCDD);
    checks++;
    if (rdata_o !== 32'h11223344) begin
      errors++;
      $display("FAIL partial_readfirst got %h want %h", rdata_o, 32'h11223344);
    end
    step(1'b1, 4'd0, 1'b0, 4'h0, 10'd3, 32'h0);
    checks++;
    if (rdata_o !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL partial_data got %h want %h", rdata_o, 32'h11BB33DD);
    end
  endtask

  task automatic test_amo_add();
    step(1'b1, 4'd0, 1'b1, 4'hF, 10'd7, 32'hFFFFFFFF);
    step(1'b1, 4'd2, 1'b0, 4'h0, 10'd7, 32'h2);
    checks++;
    if (obs_gnt !== 1'b1 || rdata_o !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL add_accept gnt %b rdata %h want 1 %h", obs_gnt, rdata_o, 32'hFFFFFFFF);
    end
    step(1'b1, 4'd0, 1'b0, 4'h0, 10'd7, 32'h0);
    checks++;
    if (obs_gnt !== 1'b0 || rdata_o !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL add_wb gnt %b rdata %h want 0 %h", obs_gnt, rdata_o, 32'hFFFFFFFF);
    end
    step(1'b1, 4'd0, 1'b0, 4'h0, 10'd7, 32'h0);
    checks++;
    if (obs_gnt !== 1'b1 || rdata_o !== 32'h00000001) begin
      errors++;
      $display("FAIL add_result gnt %b rdata %h want 1 %h", obs_gnt, rdata_o, 32'h1);
    end
  endtask

  task automatic test_signed();
    step(1'b1, 4'd0, 1'b1, 4'hF, 10'd1, 32'h80000000);
    step(1'b1, 4'd6, 1'b0, 4'h0, 10'd1, 32'h1);
    step(1'b0, 4'd0, 1'b0, 4'h0, 10'd0, 32'h0);
    step(1'b1, 4'd0, 1'b0, 4'h0, 10'd1, 32'h0);
    checks++;
    if (rdata_o !== 32'h00000001) begin
      errors++;
      $display("FAIL amo_max got %h want %h", rdata_o, 32'h1);
    end
    step(1'b1, 4'd0, 1'b1, 4'hF, 10'd1, 32'h80000000);
    step(1'b1, 4'd7, 1'b0, 4'h0, 10'd1, 32'h1);
    step(1'b0, 4'd0, 1'b0, 4'h0, 10'd0, 32'h0);
    step(1'b1, 4'd0, 1'b0, 4'h0, 10'd1, 32'h0);
    checks++;
    if (rdata_o !== 32'h80000000) begin
      errors++;
      $display("FAIL amo_maxu got %h want %h", rdata_o, 32'h80000000);
    end
  endtask

  task automatic test_reset_mid_amo();
    step(1'b1, 4'd0, 1'b1, 4'hF, 10'd9, 32'h3);
    step(1'b1, 4'd1, 1'b0, 4'h0, 10'd9, 32'h5);
    checks++;
    if (obs_gnt !== 1'b1 || rdata_o !== 32'h3) begin
      errors++;
      $display("FAIL swap_accept gnt %b rdata %h want 1 %h", obs_gnt, rdata_o, 32'h3);
    end
    @(negedge clk_i);
    req_i  = 1'b0;
    rst_ni = 1'b0;
    m_busy = 1'b0;
    m_rdata = 32'h0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    checks++;
    if (rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL midamo_rdata got %h want 0", rdata_o);
    end
    step(1'b1, 4'd0, 1'b0, 4'h0, 10'd9, 32'h0);
    checks++;
    if (obs_gnt !== 1'b1) begin
      errors++;
      $display("FAIL midamo_gnt got %b want 1", obs_gnt);
    end
    checks++;
    if (rdata_o !== 32'h3) begin
      errors++;
      $display("FAIL midamo_mem got %h want %h", rdata_o, 32'h3);
    end
  endtask

  task automatic test_reserved();
    step(1'b1, 4'd0, 1'b1, 4'hF, 10'd2, 32'h42);
    step(1'b1, 4'd12, 1'b0, 4'hF, 10'd2, 32'hFFFF);
    checks++;
    if (obs_gnt !== 1'b1 || rdata_o !== 32'h42) begin
      errors++;
      $display("FAIL reserved_first gnt %b rdata %h want 1 %h", obs_gnt, rdata_o, 32'h42);
    end
    step(1'b1, 4'd12, 1'b0, 4'hF, 10'd2, 32'hFFFF);
    checks++;
    if (obs_gnt !== 1'b1 || rdata_o !== 32'h42) begin
      errors++;
      $display("FAIL reserved_second gnt %b rdata %h want 1 %h", obs_gnt, rdata_o, 32'h42);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 1'($urandom),
           4'($urandom), 10'($urandom_range(0, 15)), $urandom);
      checks++;
      if (obs_gnt !== exp_gnt) begin
        errors++;
        $display("FAIL rand_gnt[%0d] got %b want %b", n, obs_gnt, exp_gnt);
      end
      checks++;
      if (rdata_o !== m_rdata) begin
        errors++;
        $display("FAIL rand_rdata[%0d] got %h want %h", n, rdata_o, m_rdata);
      end
    end
    step(1'b0, 4'd0, 1'b0, 4'h0, 10'd0, 32'h0);
    for (int a = 0; a < 16; a++) begin
      step(1'b1, 4'd0, 1'b0, 4'h0, 10'(a), 32'h0);
      checks++;
      if (rdata_o !== m_mem[a]) begin
        errors++;
        $display("FAIL rand_readback[%0d] got %h want %h", a, rdata_o, m_mem[a]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_read();
    test_partial();
    test_amo_add();
    test_signed();
    test_reset_mid_amo();
    test_reserved();
    test_random();
    @(negedge clk_i);
    req_i = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
